twiddle_sequencer: RTL and testbench

Generates the twiddle-number sequence for one R2²SDF multiplier stage and aligns the multiplier enable with the twiddle value. It sits between the stage's input-valid stream and the twiddle ROM. Each valid sample gets a twiddle number; that number drives the ROM address and the quarter-table converter that follow. A matched-delay enable and zero flag tell the complex multiplier when a twiddle value is valid and when the multiply can be bypassed.

---
 rtl/twiddle_sequencer.sv | 64 ++++++
 tb/tb_twiddle_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/twiddle_sequencer.sv
// twiddle_sequencer: twiddle-number generator for one R2^2SDF multiplier stage,
// with a matched-delay multiplier enable, zero flag and end-of-frame pulse.
module twiddle_sequencer #(
    parameter int LOG_N  = 6,
    parameter int TW_LAT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic             di_sof,
    output logic [LOG_N-1:0] tw_addr,
    output logic             tw_en,
    output logic             mul_en,
    output logic             mul_zero,
    output logic             frame_done,
    output logic             sof_err
);
    logic [LOG_N-1:0] cnt, idx, k, tw;
    logic [1:0]       q;
    logic             zero_r, last_r;

    // Quarter q selects multiplier {0,2,1,3}; k*m built from shifts and one add.
    always_comb begin
        idx = di_sof ? '0 : cnt;
        q   = idx[LOG_N-1 -: 2];
        k   = {2'b00, idx[LOG_N-3:0]};
        tw  = q == 2'd0 ? '0 : q == 2'd1 ? k << 1 : q == 2'd2 ? k : (k << 1) + k;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            tw_addr <= '0;
            tw_en   <= 1'b0;
            zero_r  <= 1'b0;
            last_r  <= 1'b0;
            sof_err <= 1'b0;
        end else begin
            tw_en   <= di_en;
            zero_r  <= di_en & (tw == '0);
            last_r  <= di_en & (&idx);
            sof_err <= di_en & di_sof & (cnt != '0);
            if (di_en) begin
                cnt     <= idx + 1'b1;
                tw_addr <= tw;
            end
        end
    end

    if (TW_LAT == 0) begin : g_direct
        assign {mul_en, mul_zero, frame_done} = {tw_en, zero_r, last_r};
    end else begin : g_delay
        logic [2:0] dl [TW_LAT];
        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < TW_LAT; i++) dl[i] <= '0;
            end else begin
                dl[0] <= {tw_en, zero_r, last_r};
                for (int i = 1; i < TW_LAT; i++) dl[i] <= dl[i-1];
            end
        end
        assign {mul_en, mul_zero, frame_done} = dl[TW_LAT-1];
    end
endmodule

// File: tb/tb_twiddle_sequencer.sv
// tb_twiddle_sequencer: scoreboard bench; expected twiddles come from index arithmetic.
module tb_twiddle_sequencer;
    localparam int LOG_N = 6;
    localparam int N     = 1 << LOG_N;
    localparam int LAT   = 2;

    typedef struct {
        int       cyc;
        int       addr;
        bit       zero;
        bit       last;
        bit       serr;
    } exp_t;

    logic             clock = 0, reset = 1, di_en = 0, di_sof = 0;
    logic [LOG_N-1:0] tw_addr, tw_addr0;
    logic             tw_en, mul_en, mul_zero, frame_done, sof_err;
    logic             tw_en0, mul_en0, mul_zero0, frame_done0, sof_err0;

    twiddle_sequencer #(.LOG_N(LOG_N), .TW_LAT(LAT)) dut (
        .clock(clock), .reset(reset), .di_en(di_en), .di_sof(di_sof),
        .tw_addr(tw_addr), .tw_en(tw_en), .mul_en(mul_en), .mul_zero(mul_zero),
        .frame_done(frame_done), .sof_err(sof_err)
    );

    twiddle_sequencer #(.LOG_N(LOG_N), .TW_LAT(0)) dut0 (
        .clock(clock), .reset(reset), .di_en(di_en), .di_sof(di_sof),
        .tw_addr(tw_addr0), .tw_en(tw_en0), .mul_en(mul_en0), .mul_zero(mul_zero0),
        .frame_done(frame_done0), .sof_err(sof_err0)
    );

    always #5 clock = ~clock;

    int   cyc = 0, total = 0, bad = 0, ref_cnt = 0, hold = 0;
    exp_t twq[$], mulq[$];
    int   mtab[4] = '{0, 2, 1, 3};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string name, int act, int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
        end
    endtask

    task automatic send(bit en, bit sof);
        exp_t e;
        int   i;
        @(posedge clock);
        #1;
        di_en  = en;
        di_sof = sof;
        if (en) begin
            i      = sof ? 0 : ref_cnt;
            e.addr = (i % (N / 4)) * mtab[i / (N / 4)];
            e.zero = e.addr == 0;
            e.last = i == N - 1;
            e.serr = sof && ref_cnt != 0;
            e.cyc  = cyc + 1;
            twq.push_back(e);
            e.cyc  = cyc + 1 + LAT;
            mulq.push_back(e);
            ref_cnt = (i + 1) % N;
        end
    endtask

    task automatic do_reset(int n);
        @(posedge clock);
        #1;
        reset = 1;
        di_en = 0;
        di_sof = 0;
        while (twq.size() > 0 && twq[$].cyc > cyc) void'(twq.pop_back());
        while (mulq.size() > 0 && mulq[$].cyc > cyc) void'(mulq.pop_back());
        ref_cnt = 0;
        repeat (n - 1) @(posedge clock);
        #1;
        reset = 0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        bit   exp_tw, exp_mul;
        exp_tw = twq.size() > 0 && twq[0].cyc == cyc;
        check("tw_en", tw_en, exp_tw);
        if (exp_tw) begin
            e = twq.pop_front();
            check("tw_addr", tw_addr, e.addr);
            check("sof_err", sof_err, e.serr);
            hold = e.addr;
        end else begin
            check("tw_addr_hold", tw_addr, hold);
            check("sof_err_idle", sof_err, 0);
        end
        exp_mul = mulq.size() > 0 && mulq[0].cyc == cyc;
        check("mul_en", mul_en, exp_mul);
        if (exp_mul) begin
            e = mulq.pop_front();
            check("mul_zero", mul_zero, e.zero);
            check("frame_done", frame_done, e.last);
        end else begin
            check("mul_zero_idle", mul_zero, 0);
            check("frame_done_idle", frame_done, 0);
        end
        check("lat0_mul_en", mul_en0, tw_en0);
        check("lat0_mul_zero", mul_zero0, (tw_addr0 == 0) & tw_en0);
        check("lat0_tw_addr", tw_addr0, tw_addr);
        if (reset) hold = 0;
    end

    initial begin
        do_reset(3);
        // Full frame, consecutive samples.
        for (int i = 0; i < N; i++) send(1, i == 0);
        send(0, 0);
        // Same frame with alternating gaps.
        for (int i = 0; i < 2 * N; i++) send(i % 2 == 0, i == 0);
        // Two back-to-back frames wrapping without a second sof.
        for (int i = 0; i < 2 * N; i++) send(1, i == 0);
        // Sof arriving mid-frame at index 20.
        for (int i = 0; i < 20; i++) send(1, i == 0);
        for (int i = 0; i < 30; i++) send(1, i == 0);
        send(0, 0);
        // Sof exactly at the natural wrap is legal.
        for (int i = 0; i < N + 5; i++) send(1, i == 0 || i == N);
        // Reset at index 40, then a fresh frame.
        for (int i = 0; i < 40; i++) send(1, i == 0);
        do_reset(2);
        for (int i = 0; i < N; i++) send(1, i == 0);
        // Sof while disabled is ignored.
        send(0, 1);
        send(1, 0);
        // Random traffic with occasional sof and reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3));
            else send($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end
        repeat (LAT + 4) send(0, 0);
        check("twq_drained", twq.size(), 0);
        check("mulq_drained", mulq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
